// File: rtl/tt_um_down_timer_if.sv
// Pin bundle for the down timer: reload value, control byte and the three output buses.
interface tt_um_down_timer_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic       ena;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ui_in, uio_in, ena,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ui_in, uio_in, ena,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_down_timer.sv
// Prescaled 8-bit down timer with load/start/stop control and a terminal-count pulse.
// Define DOWN_TIMER_AUTORELOAD_EN for periodic reload; default build is one-shot.
//
// state | meaning
// IDLE  | stopped, load and start accepted
// RUN   | counting down on prescaler ticks
// DONE  | one-shot expired, count is 0
module tt_um_down_timer (
    input  logic                 clk,
    input  logic                 rst_n,
    tt_um_down_timer_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] count, count_nxt;
    logic [7:0] reload, reload_nxt;
    logic [2:0] presc_cnt, presc_cnt_nxt;
    logic [1:0] presc_sel, presc_sel_nxt;
    logic       tc, tc_nxt;

    logic       load, start, stop, out_en;
    logic [1:0] p_in;
    logic [2:0] presc_mask;
    logic       tick;

    assign load   = bus.uio_in[0];
    assign start  = bus.uio_in[1];
    assign stop   = bus.uio_in[2];
    assign out_en = bus.uio_in[3];
    assign p_in   = bus.uio_in[5:4];

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.ena, bus.uio_in[7:6]};

    always_comb begin
        presc_mask = 3'd0;
        case (presc_sel)
            2'd0:    presc_mask = 3'd0;
            2'd1:    presc_mask = 3'd1;
            2'd2:    presc_mask = 3'd3;
            default: presc_mask = 3'd7;
        endcase
    end

    assign tick = (state == RUN) && (presc_cnt == presc_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= 8'd0;
            reload    <= 8'd0;
            presc_cnt <= 3'd0;
            presc_sel <= 2'd0;
            tc        <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            reload    <= reload_nxt;
            presc_cnt <= presc_cnt_nxt;
            presc_sel <= presc_sel_nxt;
            tc        <= tc_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        reload_nxt    = reload;
        presc_cnt_nxt = presc_cnt;
        presc_sel_nxt = presc_sel;
        tc_nxt        = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (load) begin
                    reload_nxt = bus.ui_in;
                    count_nxt  = bus.ui_in;
                    state_nxt  = IDLE;
                end else if (start && (reload != 8'd0)) begin
                    presc_sel_nxt = p_in;
                    presc_cnt_nxt = 3'd0;
                    count_nxt     = reload;
                    state_nxt     = RUN;
                end
            end
            RUN: begin
                // stop wins over a coincident tick: count and prescaler freeze
                if (stop) begin
                    state_nxt = IDLE;
                end else begin
                    presc_cnt_nxt = tick ? 3'd0 : presc_cnt + 3'd1;
                    if (tick) begin
                        if (count > 8'd1) begin
                            count_nxt = count - 8'd1;
                        end else if (count == 8'd1) begin
                            tc_nxt = 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
                            count_nxt = reload;
`else
                            count_nxt = 8'd0;
                            state_nxt = DONE;
`endif
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.uo_out  = out_en ? count : 8'h00;
    assign bus.uio_out = {1'b0, (state == DONE), (state == RUN), tc, 4'b0000};
    assign bus.uio_oe  = 8'hF0;
endmodule

// File: doc/tt_um_down_timer.md
TT_UM_DOWN_TIMER -- requirements
Module: tt_um_down_timer

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: ui_in  input  8  reload value R.
REQ-004 SHALL have port: uio_in  input  8  controls: [0] load, [1] start, [2] stop, [3] out_en, [5:4] prescale select P; [7:6] unused.
REQ-005 SHALL have port: uo_out  output  8  current count when out_en=1, else 8'h00 (no tri-state).
REQ-006 SHALL have port: uio_out  output  8  [4] tc, [5] busy, [6] done, [7] 0; [3:0] driven 0.
REQ-007 SHALL have port: uio_oe  output  8  constant 8'hF0.
REQ-008 SHALL have port: ena  input  1  ignored.

Function
REQ-009 SHALL hold registers: count[7:0], reload[7:0], presc_cnt[2:0], presc_sel[1:0], state {IDLE, RUN, DONE}, tc.
REQ-010 SHALL, in IDLE or DONE with load=1, set reload<=ui_in and count<=ui_in; next state IDLE.
REQ-011 SHALL, in IDLE or DONE with load=0, start=1, reload!=0: latch presc_sel<=P, clear presc_cnt, set count<=reload, enter RUN.
REQ-012 SHALL ignore start when reload==0 (stay in current state); load has priority over start in the same cycle.
REQ-013 SHALL ignore load and start while in RUN.
REQ-014 SHALL generate a decrement tick in RUN every 2^presc_sel clocks (1/2/4/8), via presc_cnt wrapping at 2^presc_sel-1; first tick 2^presc_sel clocks after entering RUN.
REQ-015 SHALL on a tick with count>1 set count<=count-1.
REQ-016 SHALL on a tick with count==1 assert tc for exactly one clock (registered, same edge as count update) and apply terminal action per REQ-026/027.
REQ-017 SHALL, on stop=1 in RUN, enter IDLE on the next edge holding count; stop has priority over a coincident tick (no decrement, no tc).
REQ-018 SHALL treat stop in IDLE/DONE as no-op.
REQ-019 SHALL drive busy=1 iff state==RUN; done=1 iff state==DONE.
REQ-020 SHALL never wrap count below 0; 8-bit arithmetic, no underflow.
REQ-021 SHALL make uo_out purely combinational from count and out_en (zero latency).

Reset
REQ-022 SHALL on rst_n=0 asynchronously clear count, reload, presc_cnt, presc_sel, tc to 0 and state to IDLE.
REQ-023 SHALL drive uo_out=0, tc=0, busy=0, done=0 during reset.
REQ-024 SHALL abort RUN on reset mid-count with no tc pulse emitted.
REQ-025 SHALL resume normal operation on first clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL, with macro DOWN_TIMER_AUTORELOAD_EN defined, on terminal tick set count<=reload and remain in RUN (tc every R ticks until stop).
REQ-027 SHALL, without DOWN_TIMER_AUTORELOAD_EN, on terminal tick set count<=0 and enter DONE (one-shot).

Verification
REQ-028 SHALL cover: load R=5, P=0, start (one-shot build) -> uo_out 5,4,3,2,1,0; tc high one cycle as count becomes 0; done=1, busy=0 after.
REQ-029 SHALL cover: R=3, P=2, start -> count decrements every 4 clocks; tc exactly 12 clocks after entering RUN.
REQ-030 SHALL cover: AUTORELOAD_EN build, R=4, P=0, run 20 clocks -> tc every 4 clocks, count sequence 4,3,2,1,4,...; stop -> IDLE, count held.
REQ-031 SHALL cover: load R=0 then start -> remains IDLE, busy=0, tc never asserts; load+start same cycle R=7 -> IDLE, count=7.
REQ-032 SHALL cover: rst_n pulsed low mid-run at count=9 -> count=0, state IDLE, no tc; out_en=0 -> uo_out=0 regardless of count.
